// File: rtl/sc_regshifter_rng_arbiter.sv
// Shares one 8-bit Fibonacci LFSR among NUM_REQ requesters, one random byte per
// round-robin grant, with a warm-up burst after reset or seed load.
module sc_regshifter_rng_arbiter #(
    parameter int          NUM_REQ       = 4,
    parameter int          WARMUP_CYCLES = 8,
    parameter logic [7:0]  RESET_SEED    = 8'h01
) (
    input  logic               SC_RegSHIFTER_CLOCK_50,
    input  logic               SC_RegSHIFTER_RESET_InHigh,
    input  logic               seed_load_In,
    input  logic [7:0]         seed_In,
    input  logic [NUM_REQ-1:0] req_In,
    output logic [NUM_REQ-1:0] grant_Out,
    output logic               valid_Out,
    output logic [7:0]         data_OutBUS,
    output logic               busy_Out
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {WARMUP, IDLE, SERVE} state_t;

    state_t             state_q;
    logic [7:0]         lfsr_q;
    logic [7:0]         lfsr_step;
    logic [7:0]         warm_q;
    logic [7:0]         seed_eff;
    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      win_d;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] grant_d;
    logic               valid_q;
    logic [7:0]         data_q;
    int                 idx;

    assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign seed_eff  = (seed_In == 8'h00) ? 8'h01 : seed_In;

    // Walk from farthest to nearest so the first set bit after ptr_q wins.
    always_comb begin
        win_d = ptr_q;
        idx   = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (req_In[idx]) win_d = PW'(idx);
        end
        grant_d = NUM_REQ'(1) << win_d;
    end

    always_ff @(posedge SC_RegSHIFTER_CLOCK_50 or posedge SC_RegSHIFTER_RESET_InHigh) begin
        if (SC_RegSHIFTER_RESET_InHigh) begin
            state_q <= WARMUP;
            lfsr_q  <= RESET_SEED;
            warm_q  <= 8'h00;
            ptr_q   <= PW'(NUM_REQ - 1);
            grant_q <= '0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else if (seed_load_In) begin
            state_q <= WARMUP;
            lfsr_q  <= seed_eff;
            warm_q  <= 8'h00;
            grant_q <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                WARMUP: begin
                    lfsr_q <= lfsr_step;
                    warm_q <= warm_q + 8'h01;
                    if (warm_q == 8'(WARMUP_CYCLES - 1)) state_q <= IDLE;
                end
                IDLE: begin
                    if (|req_In) begin
                        grant_q <= grant_d;
                        valid_q <= 1'b1;
                        data_q  <= lfsr_q;
                        ptr_q   <= win_d;
                        state_q <= SERVE;
                    end
                end
                SERVE: begin
                    lfsr_q  <= lfsr_step;
                    grant_q <= '0;
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_Out   = grant_q;
    assign valid_Out   = valid_q;
    assign data_OutBUS = data_q;
    assign busy_Out    = (state_q == WARMUP);

endmodule

// File: tb/tb_sc_regshifter_rng_arbiter.sv
// Directed bench for sc_regshifter_rng_arbiter; expected grants are queued when
// stimulus is applied and checked by a monitor whenever valid_Out is seen.
module tb_sc_regshifter_rng_arbiter;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          seed_load = 1'b0;
    logic [7:0]    seed = 8'h00;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] grant;
    logic          valid;
    logic [7:0]    data;
    logic          busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    typedef struct packed {
        logic [NR-1:0] g;
        logic [7:0]    d;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    sc_regshifter_rng_arbiter #(.NUM_REQ(NR), .WARMUP_CYCLES(8), .RESET_SEED(8'h01)) dut (
        .SC_RegSHIFTER_CLOCK_50    (clk),
        .SC_RegSHIFTER_RESET_InHigh(rst),
        .seed_load_In              (seed_load),
        .seed_In                   (seed),
        .req_In                    (req),
        .grant_Out                 (grant),
        .valid_Out                 (valid),
        .data_OutBUS               (data),
        .busy_Out                  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input logic [NR-1:0] g, input logic [7:0] d);
        exp_t e;
        e.g = g;
        e.d = d;
        q.push_back(e);
    endtask

    task automatic warm8();
        for (int k = 0; k < 8; k++) begin
            chk("warm_busy", 32'(busy), 1);
            chk("warm_nogrant", 32'(grant), 0);
            tick();
        end
        chk("warm_done_busy", 32'(busy), 0);
    endtask

    // Monitor: valid must track the grant, and every grant must be expected.
    always @(negedge clk) begin
        chk("valid_vs_grant", 32'(valid), 32'(|grant));
        if (valid === 1'b1) begin
            chk("unexpected_grant", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                chk("grant_id", 32'(grant), 32'(mon_e.g));
                chk("grant_data", 32'(data), 32'(mon_e.d));
            end
        end
    end

    logic [NR-1:0] rr_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0]    rr_d [5] = '{8'h1C, 8'h38, 8'h71, 8'hE2, 8'hC4};

    initial begin
        // Reset state and first warm-up with requester 0 held.
        req = 4'b0001;
        #1;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_busy", 32'(busy), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        warm8();
        expect_grant(4'b0001, 8'h1C);
        tick();
        chk("first_valid", 32'(valid), 1);
        tick();
        expect_grant(4'b0001, 8'h38);
        tick();
        tick();

        // Round-robin from a fresh reset with all requesters active.
        req = 4'b1111;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        warm8();
        for (int n = 0; n < 5; n++) begin
            expect_grant(rr_g[n], rr_d[n]);
            tick();
            chk("rr_valid_hi", 32'(valid), 1);
            tick();
            chk("rr_valid_lo", 32'(valid), 0);
        end

        // Zero seed behaves as seed 8'h01.
        req = '0;
        seed = 8'h00;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        warm8();
        req = 4'b0001;
        expect_grant(4'b0001, 8'h1C);
        tick();
        tick();
        req = '0;

        // Seed load colliding with a fresh request in IDLE.
        req = 4'b0010;
        seed = 8'h01;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        chk("coll_no_valid", 32'(valid), 0);
        warm8();
        expect_grant(4'b0010, 8'h1C);
        tick();
        chk("serve_grant_vis", 32'(grant), 32'(4'b0010));
        // Seed load during SERVE: grant stays this cycle, clears next.
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        chk("serve_seed_grant", 32'(grant), 0);
        chk("serve_seed_valid", 32'(valid), 0);
        req = '0;
        warm8();

        // Fairness between requesters 0 and 2; pointer sits at 1.
        req = 4'b0101;
        expect_grant(4'b0100, 8'h1C);
        tick();
        tick();
        expect_grant(4'b0001, 8'h38);
        tick();
        tick();
        expect_grant(4'b0100, 8'h71);
        tick();
        tick();

        // Withdrawn request: no grant and no LFSR step.
        req = '0;
        tick();
        chk("withdraw_valid0", 32'(valid), 0);
        tick();
        chk("withdraw_valid1", 32'(valid), 0);
        req = 4'b0001;
        expect_grant(4'b0001, 8'hE2);
        tick();
        chk("pre_rst_valid", 32'(valid), 1);

        // Async reset between edges while serving.
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_grant", 32'(grant), 0);
        chk("arst_valid", 32'(valid), 0);
        chk("arst_data", 32'(data), 0);
        chk("arst_busy", 32'(busy), 1);
        rst = 1'b0;
        req = 4'b1111;
        warm8();
        expect_grant(4'b0001, 8'h1C);
        tick();
        chk("post_rst_valid", 32'(valid), 1);
        tick();
        tick();
        chk("queue_drained", 32'(q.size()), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
